// File: rtl/sf500_pkg.sv
// Shared SF500 IDE definitions: sequencer state encoding, PIO mode-0 timing defaults
// and the register-address bit that selects the control block (CS1).
package sf500_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_ACK,
    ST_RECOVER
  } ide_state_t;

  // PIO mode 0 in 70 ns C14M cycles
  localparam int unsigned T1_CYC_DEF    = 2;
  localparam int unsigned T2_CYC_DEF    = 5;
  localparam int unsigned T2I_CYC_DEF   = 2;
  localparam int unsigned IORDY_TMO_DEF = 64;

  localparam int unsigned CS1_SEL_BIT = 3;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ide_pio_seq_sync2.sv
// Two-flop synchroniser for asynchronous CPU/drive strobes; resets to the idle level.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ide_pio_seq.sv
// IDE/ATA PIO register-cycle sequencer for the SF500 IDE card.
// Optional IORDY stretching with timeout flag: define SF500_IDE_IORDY_EN.
module ide_pio_seq
  import sf500_pkg::*;
#(
  parameter int unsigned T1_CYC    = T1_CYC_DEF,
  parameter int unsigned T2_CYC    = T2_CYC_DEF,
  parameter int unsigned T2I_CYC   = T2I_CYC_DEF,
  parameter int unsigned IORDY_TMO = IORDY_TMO_DEF
) (
  input  logic       C14M,
  input  logic       RESET,
  input  logic       AS_CPU_n,
  input  logic       DS_n,
  input  logic       RW_n,
  input  logic       IDE_SEL,
  input  logic [3:0] REG_A,
  input  logic       IORDY,
  output logic       IDE_CS0_n,
  output logic       IDE_CS1_n,
  output logic [2:0] IDE_DA,
  output logic       IDE_DIOR_n,
  output logic       IDE_DIOW_n,
  output logic       IDE_BUF_OE_n,
  output logic       IDE_BUF_DIR,
  output logic       IDE_DTACK_n,
  output logic       BUSY
`ifdef SF500_IDE_IORDY_EN
  ,
  output logic       TMO_FLAG
`endif
);

  localparam int unsigned CNT_MAX = max4(T1_CYC, T2_CYC, T2I_CYC, IORDY_TMO);
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  ide_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          as_s, ds_s, req_c;
  logic          rw_q, rw_nx;
  logic          cs0_nx, cs1_nx, dior_nx, diow_nx, oe_nx, dir_nx, dtack_nx, busy_nx;
  logic [2:0]    da_nx;

  sync2 u_sync_as (.clk(C14M), .rst(RESET), .d(AS_CPU_n), .q(as_s));
  sync2 u_sync_ds (.clk(C14M), .rst(RESET), .d(DS_n),     .q(ds_s));

  assign req_c = !as_s && !ds_s && IDE_SEL;

`ifdef SF500_IDE_IORDY_EN
  localparam int unsigned SCW = $clog2(IORDY_TMO + 1);
  logic           iordy_s, timeout_c, tmo_nx;
  logic [SCW-1:0] sc, sc_nx;

  sync2 u_sync_iordy (.clk(C14M), .rst(RESET), .d(IORDY), .q(iordy_s));
`else
  logic unused_iordy;
  assign unused_iordy = IORDY;
`endif

  // State register plus registered outputs
  always_ff @(posedge C14M) begin
    if (RESET) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      rw_q         <= 1'b1;
      IDE_CS0_n    <= 1'b1;
      IDE_CS1_n    <= 1'b1;
      IDE_DA       <= '0;
      IDE_DIOR_n   <= 1'b1;
      IDE_DIOW_n   <= 1'b1;
      IDE_BUF_OE_n <= 1'b1;
      IDE_BUF_DIR  <= 1'b0;
      IDE_DTACK_n  <= 1'b1;
      BUSY         <= 1'b0;
`ifdef SF500_IDE_IORDY_EN
      sc           <= '0;
      TMO_FLAG     <= 1'b0;
`endif
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      rw_q         <= rw_nx;
      IDE_CS0_n    <= cs0_nx;
      IDE_CS1_n    <= cs1_nx;
      IDE_DA       <= da_nx;
      IDE_DIOR_n   <= dior_nx;
      IDE_DIOW_n   <= diow_nx;
      IDE_BUF_OE_n <= oe_nx;
      IDE_BUF_DIR  <= dir_nx;
      IDE_DTACK_n  <= dtack_nx;
      BUSY         <= busy_nx;
`ifdef SF500_IDE_IORDY_EN
      sc           <= sc_nx;
      TMO_FLAG     <= tmo_nx;
`endif
    end
  end

  // Next-state and cycle counter
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
`ifdef SF500_IDE_IORDY_EN
    sc_nx     = '0;
    timeout_c = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (req_c) begin
          state_nx = ST_SETUP;
          cnt_nx   = CW'(T1_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (as_s) begin
          state_nx = ST_IDLE;
        end else if (cnt == '0) begin
          state_nx = ST_STROBE;
          cnt_nx   = CW'(T2_CYC - 1);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      ST_STROBE: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
`ifdef SF500_IDE_IORDY_EN
        end else if (iordy_s) begin
          state_nx = ST_ACK;
        end else if (sc == SCW'(IORDY_TMO)) begin
          state_nx  = ST_ACK;
          timeout_c = 1'b1;
        end else begin
          sc_nx = sc + SCW'(1);
        end
`else
        end else begin
          state_nx = ST_ACK;
        end
`endif
      end
      ST_ACK: begin
        if (as_s) begin
          state_nx = ST_RECOVER;
          cnt_nx   = CW'(T2I_CYC - 1);
        end
      end
      ST_RECOVER: begin
        if (cnt == '0) begin
          // A request already pending at the end of recovery starts without an idle gap
          if (req_c) begin
            state_nx = ST_SETUP;
            cnt_nx   = CW'(T1_CYC - 1);
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output next values, driven by the transition being taken
  always_comb begin
    rw_nx    = rw_q;
    cs0_nx   = IDE_CS0_n;
    cs1_nx   = IDE_CS1_n;
    da_nx    = IDE_DA;
    dior_nx  = IDE_DIOR_n;
    diow_nx  = IDE_DIOW_n;
    oe_nx    = IDE_BUF_OE_n;
    dir_nx   = IDE_BUF_DIR;
    dtack_nx = IDE_DTACK_n;
    busy_nx  = (state_nx != ST_IDLE);
`ifdef SF500_IDE_IORDY_EN
    tmo_nx   = TMO_FLAG | timeout_c;
`endif
    // Address/CS hold one cycle past the strobe release, or drop at once on abort
    if (state == ST_RECOVER || (state == ST_SETUP && state_nx == ST_IDLE)) begin
      cs0_nx = 1'b1;
      cs1_nx = 1'b1;
      da_nx  = '0;
      oe_nx  = 1'b1;
      dir_nx = 1'b0;
    end
    if (state_nx == ST_SETUP && state != ST_SETUP) begin
      rw_nx  = RW_n;
      da_nx  = REG_A[2:0];
      cs0_nx = REG_A[CS1_SEL_BIT];
      cs1_nx = ~REG_A[CS1_SEL_BIT];
      dir_nx = RW_n;
      oe_nx  = 1'b0;
    end
    if (state == ST_SETUP && state_nx == ST_STROBE) begin
      dior_nx = ~rw_q;
      diow_nx = rw_q;
    end
    if (state == ST_STROBE && state_nx == ST_ACK) begin
      dtack_nx = 1'b0;
    end
    if (state == ST_ACK && state_nx == ST_RECOVER) begin
      dior_nx  = 1'b1;
      diow_nx  = 1'b1;
      dtack_nx = 1'b1;
    end
  end

endmodule
